rtc_bus_reader: RTL
===================

// Module: rtc_bus_reader
// PURPOSE
// Read-side controller for the RTC's multiplexed Intel-style AD bus (ad/cs/wr/rd strobes, all active-low).
// On a start edge it optionally writes a command byte to latch the RTC time registers.
// It then runs N_REGS read cycles (address phase, then data phase with rd low) and captures each returned byte.
// It publishes all captured bytes together, with a one-cycle done pulse, to the display/time-keeping logic.
// PARAMETERS
// N_REGS    3       number of consecutive registers read per sequence (1..8)
// BASE_ADDR 8'h21   address of first register; register i uses BASE_ADDR+i (8-bit wrap)
// EN_CMD    1       1: precede reads with a command write of CMD_DATA to CMD_ADDR
// CMD_ADDR  8'hF1   command (transfer/latch) address
// CMD_DATA  8'hFF   command data byte
// T_PULSE   5       cycles wr/rd held low (>=1)
// T_GAP     8       idle cycles after each phase (>=1)
// PORTS
// clock    in   1         system clock, all logic on rising edge
// reset    in   1         asynchronous, active-low reset
// start    in   1         level; rising edge (registered start vs. previous value) launches a sequence
// ad_in    in   8         AD bus value driven by RTC during read data phase
// ad_out   out  8         AD bus value driven by this block
// ad_oe    out  1         1 = ad_out drives the AD bus
// ad       out  1         address strobe, low during address phase
// cs       out  1         chip select, active-low
// wr       out  1         write strobe, active-low
// rd       out  1         read strobe, active-low
// rd_data  out  8*N_REGS  captured bytes; register i in bits [8i+7:8i]
// busy     out  1         high from cycle after start edge until done
// done     out  1         one-cycle pulse when rd_data updated
// BEHAVIOUR
// - Reset (async, immediate): ad=cs=wr=rd=1, ad_oe=0, ad_out=8'hFF, rd_data=0, busy=0, done=0, FSM=IDLE.
//   Mid-sequence reset aborts at once; no strobe may remain low.
// - FSM: IDLE -> (EN_CMD ? CMD_A : RD_A) on start edge; CMD_A->CMD_D->RD_A; RD_A->RD_D.
//   RD_D -> RD_A (next index) or DONE after index N_REGS-1; DONE -> IDLE after 1 cycle (done=1, busy=0).
// - Address phase (CMD_A/RD_A), phase counter c from 0:
//   c0 ad=0; c1 cs=0; c2 wr=0, ad_out=addr, ad_oe=1; c2+P wr=1; c3+P cs=1; c4+P ad=1.
//   c5+P ad_oe=0, ad_out=FF; phase ends after c4+P+G, i.e. 5+P+G cycles.
// - Data phase (CMD_D/RD_D), counter c from 0: c0 cs=0.
//   c1: read -> rd=0, ad_oe stays 0; write -> wr=0, ad_out=CMD_DATA, ad_oe=1.
//   c1+P: read -> capture ad_in into shadow byte[index]; rd=1 / wr=1.
//   c2+P cs=1; c3+P ad_oe=0, ad_out=FF; phase ends after c3+P+G, i.e. 4+P+G cycles.
// - Transaction = 9+2P+2G cycles (35 at defaults). Next transaction starts on the following cycle.
// - Invariants: rd and wr never low together; ad_oe=0 whenever rd=0; ad=1 during data phases; strobes change one per cycle.
// - rd_data loads from shadow only in DONE; it is stable between done pulses; partial sequences never appear on it.
// - start edges while busy are ignored (no queueing); start held high does not retrigger until it returns low.
// - Index counter ceil(log2 N_REGS)+1 bits, reset to 0 at each sequence start; address add wraps mod 256.
// TESTING
// 1 reset low mid-RD_D with rd=0 -> same cycle rd=cs=ad=wr=1, ad_oe=0; after release, block IDLE, busy=0.
// 2 defaults, RTC model returns 8'h45,8'h30,8'h12 for 0x21..0x23 -> rd_data=24'h123045.
//   done pulses exactly 4*35+1=141 cycles after start edge detected.
// 3 EN_CMD=0, N_REGS=1, BASE_ADDR=8'hFF -> single read at addr 8'hFF, no wr-low data phase; done at 36 cycles.
// 4 Extra start pulses during busy -> exactly one sequence, one done pulse.
//   start held high across done -> no second sequence.
// 5 Bus checker every cycle -> never rd=0&&wr=0, never rd=0&&ad_oe=1.
//   wr/rd low width exactly T_PULSE; addr stable on ad_out while ad=0.
// 6 Change ad_in after capture cycle c1+P -> rd_data unaffected.
//   rd_data unchanged from done of sequence k until done of k+1.

Source files
------------

// File: rtl/rtc_bus_reader.sv
// Read-side controller for the RTC multiplexed AD bus: optional latch command write,
// then N_REGS register reads published together with a one-cycle done pulse.
module rtc_bus_reader #(
  parameter int unsigned N_REGS    = 3,
  parameter logic [7:0]  BASE_ADDR = 8'h21,
  parameter bit          EN_CMD    = 1'b1,
  parameter logic [7:0]  CMD_ADDR  = 8'hF1,
  parameter logic [7:0]  CMD_DATA  = 8'hFF,
  parameter int unsigned T_PULSE   = 5,
  parameter int unsigned T_GAP     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            ad_in,
  output logic [7:0]            ad_out,
  output logic                  ad_oe,
  output logic                  ad,
  output logic                  cs,
  output logic                  wr,
  output logic                  rd,
  output logic [8*N_REGS-1:0]   rd_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned AddrLen = 5 + T_PULSE + T_GAP;
  localparam int unsigned DataLen = 4 + T_PULSE + T_GAP;
  localparam int unsigned CntW    = $clog2(AddrLen);
  localparam int unsigned IdxW    = $clog2(N_REGS) + 1;

  localparam logic [CntW-1:0] CntAEnd = CntW'(AddrLen - 1);
  localparam logic [CntW-1:0] CntDEnd = CntW'(DataLen - 1);
  localparam logic [CntW-1:0] Cnt1    = CntW'(1);
  localparam logic [CntW-1:0] Cnt2    = CntW'(2);
  localparam logic [CntW-1:0] CntP    = CntW'(T_PULSE);
  localparam logic [CntW-1:0] CntP1   = CntW'(T_PULSE + 1);
  localparam logic [CntW-1:0] CntP2   = CntW'(T_PULSE + 2);
  localparam logic [CntW-1:0] CntP3   = CntW'(T_PULSE + 3);
  localparam logic [CntW-1:0] CntP4   = CntW'(T_PULSE + 4);
  localparam logic [CntW-1:0] CntP5   = CntW'(T_PULSE + 5);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_REGS - 1);

  typedef enum logic [2:0] {StIdle, StCmdA, StCmdD, StRdA, StRdD, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [8*N_REGS-1:0]   shadow_q, shadow_d;
  logic [8*N_REGS-1:0]   rd_data_q, rd_data_d;
  logic                  start_q;
  logic                  start_edge;
  logic                  a_end, d_end;
  logic [7:0]            phase_addr;

  assign start_edge = start & ~start_q;
  assign a_end      = (cnt_q == CntAEnd);
  assign d_end      = (cnt_q == CntDEnd);
  assign phase_addr = (state_q == StCmdA) ? CMD_ADDR : BASE_ADDR + 8'(idx_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      rd_data_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      start_q   <= start;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = EN_CMD ? StCmdA : StRdA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StCmdA: begin
        cnt_d = a_end ? '0 : cnt_q + Cnt1;
        if (a_end) state_d = StCmdD;
      end
      StCmdD: begin
        cnt_d = d_end ? '0 : cnt_q + Cnt1;
        if (d_end) state_d = StRdA;
      end
      StRdA: begin
        cnt_d = a_end ? '0 : cnt_q + Cnt1;
        if (a_end) state_d = StRdD;
      end
      StRdD: begin
        cnt_d = d_end ? '0 : cnt_q + Cnt1;
        // Sample on the edge closing the last rd-low cycle, while the RTC still drives.
        if (cnt_q == CntP) begin
          for (int i = 0; i < int'(N_REGS); i++) begin
            if (idx_q == IdxW'(i)) shadow_d[8*i +: 8] = ad_in;
          end
        end
        if (d_end) begin
          if (idx_q == IdxLast) begin
            state_d   = StDone;
            rd_data_d = shadow_q;  // valid in the same cycle done is high
          end else begin
            state_d = StRdA;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ad     = 1'b1;
    cs     = 1'b1;
    wr     = 1'b1;
    rd     = 1'b1;
    ad_oe  = 1'b0;
    ad_out = 8'hFF;
    unique case (state_q)
      StCmdA, StRdA: begin
        ad = !(cnt_q < CntP4);
        cs = !((cnt_q >= Cnt1) && (cnt_q < CntP3));
        wr = !((cnt_q >= Cnt2) && (cnt_q < CntP2));
        if ((cnt_q >= Cnt2) && (cnt_q < CntP5)) begin
          ad_oe  = 1'b1;
          ad_out = phase_addr;
        end
      end
      StCmdD: begin
        cs = !(cnt_q < CntP2);
        wr = !((cnt_q >= Cnt1) && (cnt_q < CntP1));
        if ((cnt_q >= Cnt1) && (cnt_q < CntP3)) begin
          ad_oe  = 1'b1;
          ad_out = CMD_DATA;
        end
      end
      StRdD: begin
        cs = !(cnt_q < CntP2);
        rd = !((cnt_q >= Cnt1) && (cnt_q < CntP1));
      end
      default: ;
    endcase
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q != StIdle) && (state_q != StDone);
  assign done    = (state_q == StDone);

endmodule
